// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO family.
// Imported by the storage array and the FIFO top.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 4;
  localparam int DEFAULT_DEPTH      = 16;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int count_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array with a registered read port.
// Contents are never cleared; only the read register resets.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = clog2(DEFAULT_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A read and write to the same address on one edge returns the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO: pointers, occupancy count, status flags
// and one-cycle overflow/underflow pulses around a dual-port array.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write,
  input  logic                    read,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [clog2(DEPTH):0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;

  // Request semantics: write/read are level requests evaluated every edge.
  // A write is taken when not full, or when full and a read frees a slot on
  // the same edge; a read is taken whenever not empty. Rejected requests
  // raise overflow/underflow for exactly one cycle. No fall-through.
  assign wr_acc = write & (~full | read);
  assign rd_acc = read & ~empty;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= write & ~wr_acc;
      underflow <= read & ~rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (DW=4, DEPTH=8, AF=6, AE=2) against a
// queue-based reference model.
module tb_fifo_param;

  localparam int DW    = 4;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  // clock / reset
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]    count;

  always #5 clk = ~clk;

  fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write        (write),
    .read         (read),
    .din          (din),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // reference model: contents queue plus registered outputs
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [13:0] obs;
  assign obs = {dout, count, full, empty, almost_full, almost_empty, overflow, underflow};

  function automatic logic [13:0] exp_outputs();
    int n;
    n = exp_q.size();
    return {m_dout, 4'(n), (n == DEPTH), (n == 0), (n >= AF), (n <= AE), m_ovf, m_unf};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // driver: apply one cycle of requests, advance the model, settle past the edge
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    bit wa, ra;
    @(negedge clk);
    write = w;
    read  = r;
    din   = d;
    @(posedge clk);
    wa = w && ((exp_q.size() < DEPTH) || r);
    ra = r && (exp_q.size() > 0);
    if (ra) m_dout = exp_q.pop_front();
    if (wa) exp_q.push_back(d);
    m_ovf = w && !wa;
    m_unf = r && !ra;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    write = 1'b0;
    read  = 1'b0;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (obs !== exp_outputs()) begin
      failures++;
      $display("FAIL reset_state got=%b want=%b", obs, exp_outputs());
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, '0);
      checks++;
      if (obs !== exp_outputs()) begin
        failures++;
        $display("FAIL reset_idle[%0d] got=%b want=%b", i, obs, exp_outputs());
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b0, DW'(i));
      checks++;
      if (obs !== exp_outputs()) begin
        failures++;
        $display("FAIL fill[%0d] got=%b want=%b", i, obs, exp_outputs());
      end
    end
    step(1'b0, 1'b0, '0);
    checks++;
    if (obs !== exp_outputs()) begin
      failures++;
      $display("FAIL fill_ovf_once got=%b want=%b", obs, exp_outputs());
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 1'b1, DW'($urandom_range(0, 15)));
      checks++;
      if (obs !== exp_outputs()) begin
        failures++;
        $display("FAIL drain[%0d] got=%b want=%b", i, obs, exp_outputs());
      end
    end
    step(1'b0, 1'b0, '0);
    checks++;
    if (obs !== exp_outputs()) begin
      failures++;
      $display("FAIL drain_unf_once got=%b want=%b", obs, exp_outputs());
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom_range(0, 15)));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, DW'(10 + i));
      checks++;
      if (obs !== exp_outputs()) begin
        failures++;
        $display("FAIL wrap_wr[%0d] got=%b want=%b", i, obs, exp_outputs());
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, '0);
      checks++;
      if (obs !== exp_outputs() || dout !== DW'(10 + i)) begin
        failures++;
        $display("FAIL wrap_rd[%0d] got=%b want=%b", i, obs, exp_outputs());
      end
    end
  endtask

  task automatic test_simultaneous();
    while (exp_q.size() < DEPTH) step(1'b1, 1'b0, DW'($urandom_range(0, 15)));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, DW'($urandom_range(0, 15)));
      checks++;
      if (obs !== exp_outputs()) begin
        failures++;
        $display("FAIL simul_full[%0d] got=%b want=%b", i, obs, exp_outputs());
      end
    end
    while (exp_q.size() > 0) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 4'd3);
    checks++;
    if (obs !== exp_outputs()) begin
      failures++;
      $display("FAIL simul_empty got=%b want=%b", obs, exp_outputs());
    end
    step(1'b0, 1'b1, '0);
    checks++;
    if (obs !== exp_outputs() || dout !== 4'd3) begin
      failures++;
      $display("FAIL simul_empty_read got=%b want=%b", obs, exp_outputs());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom_range(1, 15)));
    write = 1'b1;
    read  = 1'b1;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs !== exp_outputs()) begin
      failures++;
      $display("FAIL reset_async got=%b want=%b", obs, exp_outputs());
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== exp_outputs()) begin
      failures++;
      $display("FAIL reset_held got=%b want=%b", obs, exp_outputs());
    end
    @(negedge clk);
    reset = 1'b0;
    write = 1'b0;
    read  = 1'b0;
    step(1'b1, 1'b0, 4'd7);
    step(1'b0, 1'b1, '0);
    checks++;
    if (obs !== exp_outputs() || dout !== 4'd7) begin
      failures++;
      $display("FAIL reset_recover got=%b want=%b", obs, exp_outputs());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
           DW'($urandom_range(0, 15)));
      checks++;
      if (obs !== exp_outputs()) begin
        failures++;
        $display("FAIL random[%0d] got=%b want=%b", i, obs, exp_outputs());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // final report
  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
